// File: rtl/mem_region_router.sv
// Routes CPU data accesses to local data memory, one of N peripheral channels, or a bus error.
// Latency: dmem and unmapped accesses resolve combinationally; peripheral accesses take 1 + WAIT cycles + 1 DONE/ERR cycle.
// Backpressure: external_stall_to_cpu holds the CPU from request acceptance through the last WAIT cycle.
module mem_region_router #(
    parameter int ADDR_W      = 32,
    parameter int DMEM_LIMIT  = 10000,
    parameter int PERIPH_BASE = 10000,
    parameter int PERIPH_SIZE = 1000,
    parameter int N_PERIPH    = 4,
    parameter int TIMEOUT_CYC = 255,
    localparam int SEL_W      = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1,
    localparam int CNT_W      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   daddr,
    input  logic                req_valid,
    input  logic [3:0]          we_i,
    input  logic [N_PERIPH-1:0] done_periph,
    output logic [3:0]          we_o,
    output logic [N_PERIPH-1:0] en_periph,
    output logic                choose_drdata,
    output logic [SEL_W-1:0]    sel_periph,
    output logic                external_stall_to_cpu,
    output logic                bus_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [SEL_W-1:0] k_q, k_nxt;

    logic [63:0]      addr64;
    logic             hit_dmem;
    logic             hit_periph;
    logic [SEL_W-1:0] hit_k;
    logic             done_sel;

    // Address decode: dmem below DMEM_LIMIT wins, otherwise find the peripheral window (lower bound inclusive, upper exclusive).
    always_comb begin
        addr64     = 64'(daddr);
        hit_dmem   = (addr64 < 64'(DMEM_LIMIT));
        hit_periph = 1'b0;
        hit_k      = '0;
        for (int i = 0; i < N_PERIPH; i++) begin
            if (!hit_dmem &&
                (addr64 >= (64'(PERIPH_BASE) + 64'(i) * 64'(PERIPH_SIZE))) &&
                (addr64 <  (64'(PERIPH_BASE) + 64'(i + 1) * 64'(PERIPH_SIZE)))) begin
                hit_periph = 1'b1;
                hit_k      = SEL_W'(i);
            end
        end
    end

    // Completion from the latched channel only; other channels' done lines are ignored.
    always_comb begin
        done_sel = 1'b0;
        for (int i = 0; i < N_PERIPH; i++) begin
            if (k_q == SEL_W'(i)) begin
                done_sel = done_periph[i];
            end
        end
    end

    // State, timeout counter and latched channel register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            k_q     <= k_nxt;
        end
    end

    // Next-state and output decode; new requests are only accepted in IDLE and never while reset is held.
    always_comb begin
        state_nxt             = state_q;
        cnt_nxt               = cnt_q;
        k_nxt                 = k_q;
        we_o                  = 4'b0000;
        en_periph             = '0;
        choose_drdata         = 1'b1;
        external_stall_to_cpu = 1'b0;
        bus_error             = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !reset) begin
                    if (hit_dmem) begin
                        we_o = we_i;
                    end else if (hit_periph) begin
                        external_stall_to_cpu = 1'b1;
                        k_nxt                 = hit_k;
                        cnt_nxt               = '0;
                        state_nxt             = S_WAIT;
                    end else begin
                        bus_error = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                external_stall_to_cpu = 1'b1;
                for (int i = 0; i < N_PERIPH; i++) begin
                    en_periph[i] = (k_q == SEL_W'(i));
                end
                // Completion beats timeout when both land in the same cycle.
                if (done_sel) begin
                    state_nxt = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    state_nxt = S_ERR;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                choose_drdata = 1'b0;
                state_nxt     = S_IDLE;
            end
            S_ERR: begin
                bus_error = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Read-mux index follows the last latched channel at all times.
    assign sel_periph = k_q;

endmodule

// File: tb/tb_mem_region_router.sv
module tb_mem_region_router;

    localparam int DMEM_LIMIT  = 10000;
    localparam int PBASE       = 10000;
    localparam int PSIZE       = 1000;
    localparam int NP          = 4;
    localparam int TOUT        = 4;

    logic        clk;
    logic        reset;
    logic [31:0] daddr;
    logic        req_valid;
    logic [3:0]  we_i;
    logic [3:0]  done_periph;
    logic [3:0]  we_o;
    logic [3:0]  en_periph;
    logic        choose_drdata;
    logic [1:0]  sel_periph;
    logic        external_stall_to_cpu;
    logic        bus_error;

    logic [12:0] obs;
    assign obs = {external_stall_to_cpu, en_periph, we_o, choose_drdata, sel_periph, bus_error};

    int          n_checks;
    int          n_fail;
    logic [1:0]  model_sel;

    mem_region_router #(
        .ADDR_W(32), .DMEM_LIMIT(DMEM_LIMIT), .PERIPH_BASE(PBASE),
        .PERIPH_SIZE(PSIZE), .N_PERIPH(NP), .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk(clk), .reset(reset), .daddr(daddr), .req_valid(req_valid),
        .we_i(we_i), .done_periph(done_periph), .we_o(we_o),
        .en_periph(en_periph), .choose_drdata(choose_drdata),
        .sel_periph(sel_periph), .external_stall_to_cpu(external_stall_to_cpu),
        .bus_error(bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Region model: -1 dmem, -2 unmapped, otherwise channel number.
    function automatic int decode(input logic [31:0] a);
        if (a < 32'(DMEM_LIMIT)) return -1;
        if (a >= 32'(PBASE) && a < 32'(PBASE + NP * PSIZE))
            return int'((a - 32'(PBASE)) / 32'(PSIZE));
        return -2;
    endfunction

    function automatic logic [12:0] expv(input logic st, input logic [3:0] en, input logic [3:0] we,
                                         input logic ch, input logic [1:0] sel, input logic be);
        return {st, en, we, ch, sel, be};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        reset = 1'b1; req_valid = 1'b0; daddr = 32'd0; we_i = 4'b0; done_periph = 4'b0;
        next_cycle();
        next_cycle();
        #1;
        e = expv(1'b0, 4'b0, 4'b0, 1'b1, 2'd0, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", obs, e);
        end
        reset = 1'b0;
        model_sel = 2'd0;
        next_cycle();
    endtask

    // One IDLE-cycle access that must not start a transaction (dmem or unmapped).
    task automatic test_single_access(input logic [31:0] addr, input logic valid, input logic [3:0] we);
        logic [12:0] e;
        int r;
        r = decode(addr);
        req_valid = valid; daddr = addr; we_i = we; done_periph = 4'($urandom);
        #1;
        if (r == -1)
            e = expv(1'b0, 4'b0, valid ? we : 4'b0, 1'b1, model_sel, 1'b0);
        else
            e = expv(1'b0, 4'b0, 4'b0, 1'b1, model_sel, valid);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL single_access addr=%0d valid=%b got=%b exp=%b", addr, valid, obs, e);
        end
        next_cycle();
    endtask

    task automatic test_dmem();
        test_single_access(32'd9999, 1'b1, 4'b1111);
        test_single_access(32'd0, 1'b1, 4'b0101);
        test_single_access(32'd9999, 1'b0, 4'b1111);
        for (int i = 0; i < 4; i++)
            test_single_access(32'($urandom_range(0, DMEM_LIMIT - 1)), 1'($urandom), 4'($urandom));
    endtask

    task automatic test_unmapped();
        test_single_access(32'd14000, 1'b1, 4'b1111);
        test_single_access(32'd14000, 1'b0, 4'b0000);
        test_single_access(32'hFFFF_FFFF, 1'b1, 4'b0011);
        test_single_access(32'd9999, 1'b1, 4'b1000);
        for (int i = 0; i < 3; i++)
            test_single_access(32'd14000 + 32'($urandom_range(0, 100000)), 1'b1, 4'($urandom));
    endtask

    // Peripheral transaction; done on the addressed channel arrives in WAIT cycle d (1-based).
    task automatic test_periph_txn(input logic [31:0] addr, input int d, input logic rnd_noise,
                                   input logic [3:0] fixed_noise);
        logic [12:0] e;
        logic [3:0]  oh;
        logic [3:0]  nz;
        logic [1:0]  k;
        int          waits;
        logic        ok;
        k     = 2'(decode(addr));
        oh    = 4'b0001 << k;
        ok    = (d <= TOUT + 1);
        waits = ok ? d : TOUT + 1;
        req_valid = 1'b1; daddr = addr; we_i = 4'($urandom); done_periph = 4'($urandom);
        #1;
        e = expv(1'b1, 4'b0, 4'b0, 1'b1, model_sel, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL periph_accept addr=%0d got=%b exp=%b", addr, obs, e);
        end
        model_sel = k;
        next_cycle();
        for (int j = 1; j <= waits; j++) begin
            nz = (rnd_noise ? 4'($urandom) : fixed_noise) & ~oh;
            req_valid = 1'($urandom); daddr = $urandom; we_i = 4'($urandom);
            done_periph = nz | ((j == d) ? oh : 4'b0);
            #1;
            e = expv(1'b1, oh, 4'b0, 1'b1, k, 1'b0);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL periph_wait addr=%0d cyc=%0d got=%b exp=%b", addr, j, obs, e);
            end
            next_cycle();
        end
        req_valid = 1'b0; done_periph = 4'b0; we_i = 4'($urandom);
        #1;
        e = ok ? expv(1'b0, 4'b0, 4'b0, 1'b0, k, 1'b0) : expv(1'b0, 4'b0, 4'b0, 1'b1, k, 1'b1);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL periph_end addr=%0d d=%0d got=%b exp=%b", addr, d, obs, e);
        end
        next_cycle();
    endtask

    task automatic test_periph();
        test_periph_txn(32'd10000, 2, 1'b1, 4'b0);
        test_periph_txn(32'd11999, 1, 1'b1, 4'b0);
        test_periph_txn(32'd12500, 3, 1'b0, 4'b0);
        test_periph_txn(32'd10999, 1, 1'b0, 4'b0);
        test_periph_txn(32'd13999, 2, 1'b1, 4'b0);
    endtask

    task automatic test_timeout();
        test_periph_txn(32'd11500, 99, 1'b0, 4'b0001);
        test_periph_txn(32'd10500, TOUT + 1, 1'b1, 4'b0);
        test_periph_txn(32'd13000, TOUT + 2, 1'b1, 4'b0);
        test_single_access(32'd9000, 1'b1, 4'b0110);
    endtask

    task automatic test_reset_in_wait();
        logic [12:0] e;
        req_valid = 1'b1; daddr = 32'd12100; we_i = 4'b1111; done_periph = 4'b0;
        next_cycle();
        req_valid = 1'b0; done_periph = 4'b0;
        next_cycle();
        reset = 1'b1; done_periph = 4'b0100;
        #1;
        e = expv(1'b1, 4'b0100, 4'b0, 1'b1, 2'd2, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_wait_pre got=%b exp=%b", obs, e);
        end
        next_cycle();
        reset = 1'b0; done_periph = 4'b0;
        model_sel = 2'd0;
        #1;
        e = expv(1'b0, 4'b0, 4'b0, 1'b1, 2'd0, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_wait_abort got=%b exp=%b", obs, e);
        end
        next_cycle();
        #1;
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_wait_idle got=%b exp=%b", obs, e);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 2))
                0: test_single_access(32'($urandom_range(0, DMEM_LIMIT - 1)), 1'($urandom), 4'($urandom));
                1: test_single_access(32'(PBASE + NP * PSIZE) + 32'($urandom_range(0, 50000)), 1'($urandom), 4'($urandom));
                default: begin
                    a = 32'($urandom_range(PBASE, PBASE + NP * PSIZE - 1));
                    test_periph_txn(a, $urandom_range(1, TOUT + 3), 1'b1, 4'b0);
                end
            endcase
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_sel = 2'd0;
        test_reset();
        test_dmem();
        test_unmapped();
        test_periph();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_region_router.md
MEM_REGION_ROUTER -- requirements
Module: mem_region_router

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, data-address width.
REQ-002 SHALL have parameter DMEM_LIMIT, default 10000, first address past local data memory.
REQ-003 SHALL have parameter PERIPH_BASE, default 10000, first peripheral address.
REQ-004 SHALL have parameter PERIPH_SIZE, default 1000, bytes per peripheral window.
REQ-005 SHALL have parameter N_PERIPH, default 4, peripheral channel count (1..16).
REQ-006 SHALL have parameter TIMEOUT_CYC, default 255, maximum WAIT cycles before abort.
REQ-007 SHALL have ports: clk in 1 clock; reset in 1 synchronous active-high reset; single clock, all state on rising clk edge.
REQ-008 SHALL have ports: daddr in ADDR_W CPU data address; req_valid in 1 CPU access strobe; we_i in 4 CPU byte write enables.
REQ-009 SHALL have ports: done_periph in N_PERIPH per-channel completion; we_o out 4 dmem byte enables; en_periph out N_PERIPH one-hot channel enable.
REQ-010 SHALL have ports: choose_drdata out 1 (1 = dmem, 0 = peripheral); sel_periph out clog2(N_PERIPH) read-mux index; external_stall_to_cpu out 1; bus_error out 1 one-cycle pulse.

Function
REQ-011 SHALL decode: DMEM when daddr < DMEM_LIMIT; channel k when PERIPH_BASE + k*PERIPH_SIZE <= daddr < PERIPH_BASE + (k+1)*PERIPH_SIZE; otherwise UNMAPPED; lower bounds inclusive, upper exclusive.
REQ-012 SHALL, for a DMEM access, drive we_o = we_i and choose_drdata = 1 combinationally, with no stall; we_o SHALL be 0 for every non-DMEM or non-valid access.
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE, ERR.
REQ-014 IDLE: req_valid with channel-k decode SHALL assert external_stall_to_cpu combinationally the same cycle, latch k and go to WAIT.
REQ-015 WAIT: en_periph SHALL be one-hot at latched k, stall SHALL stay 1, the timeout counter SHALL increment each cycle.
REQ-016 WAIT: done_periph[k] sampled 1 SHALL go to DONE; done on any other channel SHALL be ignored.
REQ-017 DONE (one cycle): stall 0, en_periph 0, choose_drdata 0, sel_periph = k; then IDLE.
REQ-018 WAIT with counter = TIMEOUT_CYC and done_periph[k] = 0 SHALL go to ERR; done and timeout in the same cycle SHALL resolve to DONE.
REQ-019 ERR (one cycle): bus_error 1, stall 0, en_periph 0; then IDLE.
REQ-020 IDLE with req_valid and UNMAPPED decode SHALL pulse bus_error for that cycle with no stall and no state change.
REQ-021 The counter SHALL clear on WAIT entry; width SHALL be clog2(TIMEOUT_CYC+1); no wrap-around.
REQ-022 sel_periph SHALL hold the last latched k outside DONE; choose_drdata SHALL be 1 outside DONE.
REQ-023 daddr/req_valid changes during WAIT SHALL be ignored (request latched).

Reset
REQ-024 reset SHALL force IDLE, counter 0, latched k 0, en_periph 0, bus_error 0, stall 0, sel_periph 0, choose_drdata 1 on the next clk edge.
REQ-025 reset asserted during WAIT SHALL abort the transaction without bus_error; reset SHALL override done_periph.

Verification
REQ-026 req_valid, daddr=9999, we_i=4'b1111 -> we_o=4'b1111, choose_drdata=1, stall 0, state IDLE.
REQ-027 daddr=10000 (boundary) then 11999 -> channel 0 then channel 1 selected; en_periph=4'b0001 / 4'b0010 in WAIT; we_o=0.
REQ-028 daddr=12500, done_periph[2] after 3 WAIT cycles -> stall high 4 cycles (IDLE + 3 WAIT), DONE with sel_periph=2, choose_drdata=0, then IDLE.
REQ-029 channel 1 access, done_periph[0] only, TIMEOUT_CYC=4 -> stall held, then ERR with bus_error one pulse, stall released.
REQ-030 daddr=14000 (UNMAPPED, N_PERIPH=4) -> bus_error one cycle, stall 0, en_periph 0.
REQ-031 reset in 2nd WAIT cycle -> next edge: IDLE, en_periph 0, stall 0, bus_error 0.
